// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: next-PC select encodings,
// default reset PC, nop word and the F/D register bundle.
package fetch_pkg;

    localparam logic [1:0] NPC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] NPC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] NPC_SEL_JUMP   = 2'b10;
    localparam logic [1:0] NPC_SEL_JR     = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

endpackage

// File: rtl/f_npc.sv
// Combinational next-PC mux. Inputs: F_pc, D_pc, D_instr, npc_sel,
// Branch_or_not, D_rs_data. Output: npc (PC to load at the next edge).
module f_npc
    import fetch_pkg::*;
(
    input  logic [31:0] F_pc,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_instr,
    input  logic [1:0]  npc_sel,
    input  logic        Branch_or_not,
    input  logic [31:0] D_rs_data,
    output logic [31:0] npc
);

    logic [31:0] br_off;

    assign br_off = {{14{D_instr[15]}}, D_instr[15:0], 2'b00};

    always_comb begin
        npc = F_pc + 32'd4;
        case (npc_sel)
            NPC_SEL_BRANCH: begin
                if (Branch_or_not) begin
                    npc = D_pc + 32'd4 + br_off;
                end
            end
            NPC_SEL_JUMP: npc = {D_pc[31:28], D_instr[25:0], 2'b00};
            NPC_SEL_JR:   npc = D_rs_data;
            default:      ;
        endcase
    end

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: PC register, F/D pipeline register, stall gating.
// Ports: clk, reset (sync, active-low), stall, npc_sel, Branch_or_not,
// D_rs_data, F_instr in; F_pc, D_pc, D_instr out.
// Optional macro FETCH_ADEL_EN adds D_exc_adel (fetch address fault).
module f_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        Branch_or_not,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] F_instr,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr
`ifdef FETCH_ADEL_EN
    ,
    output logic        D_exc_adel
`endif
);

    logic [31:0] npc;
    if_id_t      fd_q;

    f_npc u_npc (
        .F_pc          (F_pc),
        .D_pc          (fd_q.pc),
        .D_instr       (fd_q.instr),
        .npc_sel       (npc_sel),
        .Branch_or_not (Branch_or_not),
        .D_rs_data     (D_rs_data),
        .npc           (npc)
    );

    assign D_pc    = fd_q.pc;
    assign D_instr = fd_q.instr;

`ifdef FETCH_ADEL_EN
    // 33-bit end bound so a window touching 2^32 still compares correctly.
    localparam logic [32:0] IM_END =
        {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    logic fetch_fault;

    assign fetch_fault = (F_pc[1:0] != 2'b00)
                       || (F_pc < IM_BASE)
                       || ({1'b0, F_pc} >= IM_END);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            F_pc       <= RESET_PC;
            fd_q.pc    <= 32'h0;
            fd_q.instr <= NOP_WORD;
`ifdef FETCH_ADEL_EN
            D_exc_adel <= 1'b0;
`endif
        end else if (!stall) begin
            F_pc       <= npc;
            fd_q.pc    <= F_pc;
`ifdef FETCH_ADEL_EN
            // Faulting fetch enters D as a nop tagged with the bad PC.
            fd_q.instr <= fetch_fault ? NOP_WORD : F_instr;
            D_exc_adel <= fetch_fault;
`else
            fd_q.instr <= F_instr;
`endif
        end
    end

endmodule

// File: doc/f_fetch_unit.md
# f_fetch_unit

Fetch-stage block of the five-stage MIPS pipeline: holds the program counter, computes the next PC and owns the F/D pipeline register. It is the consumer of the D-stage branch decision (`Branch_or_not`) and the jump selects decoded in D. Its `D_instr`/`D_pc` outputs feed the D-stage controller and comparator, which return the redirect request to this block in the same cycle. Architectural branch delay slot: no flush on redirect.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value loaded at reset.
- `IM_BASE`, 32'h0000_3000, first legal instruction address.
- `IM_WORDS`, 4096, instruction memory depth in words.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-low (asserted when 0).
- `stall`  input  1  from hazard unit; freezes PC and F/D register.
- `npc_sel`  input  2  D-stage next-PC select: 00 seq, 01 branch, 10 j/jal, 11 jr.
- `Branch_or_not`  input  1  D-stage comparator result for the instruction in D.
- `D_rs_data`  input  32  forwarded rs value for jr/jalr.
- `F_instr`  input  32  instruction word read from IM at `F_pc`.
- `F_pc`  output  32  current fetch address to IM.
- `D_pc`  output  32  PC of the instruction in D.
- `D_instr`  output  32  instruction in D.

## Operation
- PC register `F_pc`; F/D register {`D_pc`, `D_instr`}.
- Next PC (computed from the instruction in D):
  - 00, or 01 with `Branch_or_not`=0: `F_pc`+4.
  - 01 with `Branch_or_not`=1: `D_pc`+4+(sext(`D_instr`[15:0])<<2).
  - 10: {`D_pc`[31:28], `D_instr`[25:0], 2'b00}.
  - 11: `D_rs_data` (unmodified, no bit masking).
- All arithmetic 32-bit modulo 2^32; wrap-around is silent.
- Delay slot: when D holds a taken branch/jump, F holds `D_pc`+4; it advances into D normally, and the target is fetched next.
- Each unstalled cycle: `F_pc`<=next PC, `D_pc`<=`F_pc`, `D_instr`<=`F_instr`.
- `stall`=1: all three registers hold; `npc_sel`/`Branch_or_not` ignored that cycle. Redirect takes effect in the first unstalled cycle with the branch still in D.

## Timing
- Reset (reset=0 at edge): `F_pc`=RESET_PC, `D_pc`=0, `D_instr`=0 (nop). Reset beats `stall`. Reset mid-redirect discards the redirect.
- Fetch-to-D latency: 1 cycle. Redirect latency: target appears on `F_pc` one edge after the branch is in D and unstalled.
- `npc_sel` and `Branch_or_not` are combinational functions of D outputs; must be stable before the edge; no internal registering.
- `F_instr` is combinational IM read data, sampled at the same edge.

## Configuration
- `FETCH_ADEL_EN` defined: adds output `D_exc_adel` (1 bit, reset 0). Fetch fault when `F_pc`[1:0]!=0 or `F_pc` outside [IM_BASE, IM_BASE+4*IM_WORDS). On an unstalled edge with a fault: `D_exc_adel`<=1, `D_instr`<=0; `D_pc`<=faulting `F_pc`. Otherwise `D_exc_adel`<=0. It holds under `stall`.
- Not defined: no `D_exc_adel` port; `F_instr` always latched as-is, with no address checks.

## Structure
- Shared package `fetch_pkg`: NPC_SEL_SEQ/BRANCH/JUMP/JR encodings, default RESET_PC, NOP word 32'h0.
- Sub-module `f_npc`: combinational next-PC mux (inputs `F_pc`, `D_pc`, `D_instr`, `npc_sel`, `Branch_or_not`, `D_rs_data`). `f_fetch_unit` holds only registers, stall gating and the optional fault check.

## Test plan
- Reset for 2 cycles, release, no stalls, `npc_sel`=00 -> `F_pc` 3000, 3004, 3008; `D_pc` lags by one cycle; `D_instr`=0 in the first cycle after reset.
- Branch at 3008 in D with imm16=16'hFFFE, `npc_sel`=01, `Branch_or_not`=1 -> delay slot 300C enters D, then `F_pc`=3004. Same stimulus with `Branch_or_not`=0 -> `F_pc`=3010.
- `D_pc`=3010, `npc_sel`=10, index=26'h0000C20 -> `F_pc`=00003080. `npc_sel`=11, `D_rs_data`=32'h0000_31F0 -> `F_pc`=31F0.
- Taken branch in D with `stall`=1 for 3 cycles -> `F_pc`, `D_pc` and `D_instr` frozen; redirect applied on the first edge with `stall`=0.
- reset=0 asserted together with `stall`=1 and a taken jr -> `F_pc`=3000, `D_instr`=0.
- With `FETCH_ADEL_EN`, jr to 32'h0000_3002 -> next D has `D_exc_adel`=1, `D_instr`=0, `D_pc`=3002. Jr to 32'h0000_7000 -> `D_exc_adel`=1.
